cbus_aging_arbiter: RTL



---
 rtl/cbus_aging_arbiter_pkg.sv | 39 +++
 rtl/cbus_aging_arbiter_if.sv | 23 ++
 rtl/cbus_aging_arbiter_pick.sv | 40 ++++
 rtl/cbus_aging_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/cbus_aging_arbiter_pkg.sv
// ============================================================================
// Module   : cbus_aging_arbiter_pkg
// Purpose  : CBus request/response types and arbiter state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cbus_aging_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Age counters must hold 0..AGE_LIMIT inclusive.
    function automatic int age_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cbus_aging_arbiter_if.sv
// ============================================================================
// Module   : cbus_aging_arbiter_if
// Purpose  : Requester-side and memory-side CBus bundle around the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cbus_aging_arbiter_if #(
    parameter int NUM_REQS = 2
);
    import cbus_aging_arbiter_pkg::*;

    cbus_req_t  [NUM_REQS-1:0] ireqs;
    cbus_resp_t [NUM_REQS-1:0] iresps;
    cbus_req_t                 oreq;
    cbus_resp_t                oresp;

    modport slave  (input  ireqs, output iresps, output oreq, input  oresp);
    modport master (output ireqs, input  iresps, input  oreq, output oresp);

endinterface

`default_nettype wire

// File: rtl/cbus_aging_arbiter_pick.sv
// ============================================================================
// Module   : cbus_arb_pick
// Purpose  : Combinational winner select: lowest-index aged requester first,
//            otherwise the highest-index valid requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cbus_arb_pick #(
    parameter int NUM_REQS  = 2,
    parameter int AGE_W     = 4,
    parameter int AGE_LIMIT = 8,
    parameter int SEL_W     = 1
) (
    input  wire logic [NUM_REQS-1:0]            i_valid,
    input  wire logic [NUM_REQS-1:0][AGE_W-1:0] i_ages,
    output logic      [SEL_W-1:0]               o_idx,
    output logic                                o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (i_valid[i]) begin
                o_idx   = SEL_W'(i);
                o_found = 1'b1;
            end
        end
        // Descending scan so the lowest-index aged requester is written last.
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_ages[i] == AGE_W'(AGE_LIMIT))) begin
                o_idx = SEL_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cbus_aging_arbiter.sv
// ============================================================================
// Module   : cbus_aging_arbiter
// Purpose  : Fixed-priority CBus arbiter with per-requester aging; the grant
//            is held for a whole burst. Optional counters: CBUS_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cbus_aging_arbiter #(
    parameter int NUM_REQS  = 2,
    parameter int AGE_LIMIT = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    cbus_aging_arbiter_if.slave       bus
`ifdef CBUS_ARB_PERF_EN
    ,
    output logic [NUM_REQS-1:0][31:0] perf_grants,
    output logic [31:0]               perf_wait
`endif
);
    import cbus_aging_arbiter_pkg::*;

    localparam int AGE_W = age_width(AGE_LIMIT);
    localparam int SEL_W = $clog2(NUM_REQS);

    arb_state_t                       r_state;
    logic [SEL_W-1:0]                 r_sel;
    logic [NUM_REQS-1:0][AGE_W-1:0]   r_age;

    logic [NUM_REQS-1:0] w_valid;
    logic [SEL_W-1:0]    w_pick_idx;
    logic                w_pick_found;
    logic                w_sel_valid;
    logic                w_done;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_valid[i] = bus.ireqs[i].valid;
        end
    end

    assign w_sel_valid = bus.ireqs[r_sel].valid;
    assign w_done      = bus.oresp.ready && bus.oresp.last;

    cbus_arb_pick #(
        .NUM_REQS  (NUM_REQS),
        .AGE_W     (AGE_W),
        .AGE_LIMIT (AGE_LIMIT),
        .SEL_W     (SEL_W)
    ) u_pick (
        .i_valid (w_valid),
        .i_ages  (r_age),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_sel   <= '0;
            r_age   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    // Every idle cycle is an arbitration round for the ages.
                    for (int i = 0; i < NUM_REQS; i++) begin
                        if (!w_valid[i] || (w_pick_idx == SEL_W'(i))) begin
                            r_age[i] <= '0;
                        end else if (r_age[i] != AGE_W'(AGE_LIMIT)) begin
                            r_age[i] <= r_age[i] + 1'b1;
                        end
                    end
                    if (w_pick_found) begin
                        r_sel   <= w_pick_idx;
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (w_done || !w_sel_valid) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Output steering follows the state register, so an async reset
    // silences the bus in the same cycle.
    always_comb begin
        bus.oreq   = '0;
        bus.iresps = '0;
        if (r_state == ARB_BUSY) begin
            bus.oreq          = bus.ireqs[r_sel];
            bus.iresps[r_sel] = bus.oresp;
        end
    end

`ifdef CBUS_ARB_PERF_EN
    logic [NUM_REQS-1:0] w_grant_vec;
    logic                w_waiting;

    always_comb begin
        w_grant_vec = '0;
        if (r_state == ARB_BUSY) begin
            w_grant_vec[r_sel] = 1'b1;
        end
    end

    assign w_waiting = |(w_valid & ~w_grant_vec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_grants <= '0;
            perf_wait   <= '0;
        end else begin
            if ((r_state == ARB_BUSY) && w_done) begin
                perf_grants[r_sel] <= perf_grants[r_sel] + 32'd1;
            end
            if (w_waiting) begin
                perf_wait <= perf_wait + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
